local_port_interface: RTL and testbench

// - PE-side end of a router's local port.
// - TX path:
//   - Buffers packets offered by the PE.
//   - Injects them into the router's local input queue using the codebase data/val/en handshake.
// - RX path:
//   - Accepts packets granted to the router's local output.
//   - Buffers them and hands them to the PE with valid/ready.
// - Keeps wrap-around TX/RX packet counters and a sticky RX overflow flag for the testbench.

---
 rtl/local_port_interface.sv | 119 +++++++++++
 tb/tb_local_port_interface.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_port_interface.sv
// PE-side end of a router local port: a TX FIFO injects PE packets into the router,
// and an RX FIFO buffers router deliveries for the PE. Also keeps packet counters and a sticky overflow flag.
package local_port_pkg;
  typedef struct packed {
    logic [3:0]  dst;
    logic [27:0] payload;
  } packet_t;
endpackage

module local_port_interface
  import local_port_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          i_pe_data,
  input  logic             i_pe_val,
  output logic             o_pe_rdy,
  output packet_t          o_data,
  output logic             o_data_val,
  input  logic             i_en,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  output packet_t          o_pe_data,
  output logic             o_pe_val,
  input  logic             i_pe_rdy,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic             o_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);

  // ---------------- TX path ----------------
  packet_t          tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_occ;
  logic             tx_push, tx_pop;

  assign o_pe_rdy   = (tx_occ != TX_FULL);
  assign o_data_val = (tx_occ != '0) & i_en;
  assign o_data     = tx_mem[tx_rd_ptr];
  assign tx_push    = i_pe_val & o_pe_rdy;
  assign tx_pop     = o_data_val;

  // NOTE: buffer storage is deliberately left out of reset; occupancy alone decides
  // what is visible, and a reset-free array maps onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= i_pe_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_occ     <= '0;
      o_tx_count <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop) begin
        tx_rd_ptr  <= tx_rd_ptr + 1'b1;
        o_tx_count <= o_tx_count + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_occ <= tx_occ + 1'b1;
        2'b01:   tx_occ <= tx_occ - 1'b1;
        default: tx_occ <= tx_occ;
      endcase
    end
  end

  // ---------------- RX path ----------------
  packet_t          rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_occ;
  logic             rx_full, rx_write, rx_pop;

  // o_en depends only on registered occupancy so no path runs from i_pe_rdy to the router.
  assign rx_full   = (rx_occ == RX_FULL);
  assign o_en      = ~rx_full;
  assign o_pe_val  = (rx_occ != '0);
  assign o_pe_data = rx_mem[rx_rd_ptr];
  assign rx_write  = i_data_val & ~rx_full;
  assign rx_pop    = o_pe_val & i_pe_rdy;

  always_ff @(posedge clk) begin
    if (rx_write) rx_mem[rx_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_occ     <= '0;
      o_rx_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (rx_write) begin
        rx_wr_ptr  <= rx_wr_ptr + 1'b1;
        o_rx_count <= o_rx_count + 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (i_data_val && rx_full) o_overflow <= 1'b1;
      case ({rx_write, rx_pop})
        2'b10:   rx_occ <= rx_occ + 1'b1;
        2'b01:   rx_occ <= rx_occ - 1'b1;
        default: rx_occ <= rx_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_local_port_interface.sv
// Scoreboard bench for local_port_interface: directed TX/RX/overflow scenarios, random concurrent
// traffic, and a second small-counter instance for counter wrap and mid-run reset.
module tb_local_port_interface;
  import local_port_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main instance (CNT_W=16) ----------------
  logic        reset_n = 1'b0;
  packet_t     pe_data = '0;
  logic        pe_val = 1'b0;
  logic        pe_rdy;
  packet_t     r_data;
  logic        r_data_val;
  logic        en_in = 1'b0;
  packet_t     d_in = '0;
  logic        d_in_val = 1'b0;
  logic        en_out;
  packet_t     pe_out_data;
  logic        pe_out_val;
  logic        pe_out_rdy = 1'b0;
  logic [15:0] tx_count, rx_count;
  logic        overflow;

  local_port_interface #(.TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pe_data(pe_data), .i_pe_val(pe_val), .o_pe_rdy(pe_rdy),
    .o_data(r_data), .o_data_val(r_data_val), .i_en(en_in),
    .i_data(d_in), .i_data_val(d_in_val), .o_en(en_out),
    .o_pe_data(pe_out_data), .o_pe_val(pe_out_val), .i_pe_rdy(pe_out_rdy),
    .o_tx_count(tx_count), .o_rx_count(rx_count), .o_overflow(overflow)
  );

  // ---------------- wrap instance (CNT_W=4) ----------------
  logic       w_reset_n = 1'b0;
  packet_t    w_pe_data = '0;
  logic       w_pe_val = 1'b0;
  logic       w_pe_rdy;
  packet_t    w_r_data;
  logic       w_r_data_val;
  logic       w_en_in = 1'b0;
  packet_t    w_d_in = '0;
  logic       w_d_in_val = 1'b0;
  logic       w_en_out;
  packet_t    w_pe_out_data;
  logic       w_pe_out_val;
  logic       w_pe_out_rdy = 1'b0;
  logic [3:0] w_tx_count, w_rx_count;
  logic       w_overflow;

  local_port_interface #(.TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(4)) dut_w (
    .clk(clk), .reset_n(w_reset_n),
    .i_pe_data(w_pe_data), .i_pe_val(w_pe_val), .o_pe_rdy(w_pe_rdy),
    .o_data(w_r_data), .o_data_val(w_r_data_val), .i_en(w_en_in),
    .i_data(w_d_in), .i_data_val(w_d_in_val), .o_en(w_en_out),
    .o_pe_data(w_pe_out_data), .o_pe_val(w_pe_out_val), .i_pe_rdy(w_pe_out_rdy),
    .o_tx_count(w_tx_count), .o_rx_count(w_rx_count), .o_overflow(w_overflow)
  );

  // ---------------- scoreboard ----------------
  packet_t tx_exp[$];
  packet_t rx_exp[$];

  always @(negedge clk) begin
    if (r_data_val === 1'b1) begin
      if (tx_exp.size() == 0) check("tx_unexpected_packet", 1, 0);
      else check("tx_data", r_data, tx_exp.pop_front());
    end
    if (pe_out_val === 1'b1 && pe_out_rdy === 1'b1) begin
      if (rx_exp.size() == 0) check("rx_unexpected_packet", 1, 0);
      else check("rx_data", pe_out_data, rx_exp.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    packet_t pk;
    int tx_sent, rx_sent;

    // Reset and idle
    repeat (2) next_cycle();
    reset_n = 1'b1;
    en_in   = 1'b1;
    @(negedge clk);
    check("rst_pe_rdy", pe_rdy, 1);
    check("rst_en", en_out, 1);
    check("rst_data_val", r_data_val, 0);
    check("rst_pe_val", pe_out_val, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_overflow", overflow, 0);

    // TX ordering: A, B, C on consecutive cycles
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      pk = '{dst: 4'(i + 1), payload: 28'hA00 + 28'(i)};
      pe_data = pk;
      pe_val  = 1'b1;
      tx_exp.push_back(pk);
      @(negedge clk);
      check("ord_data_val", r_data_val, (i > 0));
      next_cycle();
    end
    pe_val = 1'b0;
    @(negedge clk);
    check("ord_data_val_last", r_data_val, 1);
    next_cycle();
    @(negedge clk);
    check("ord_idle_val", r_data_val, 0);
    check("ord_tx_count", tx_count, 3);

    // TX backpressure: five pushes with router blocked, only four accepted
    next_cycle();
    en_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pk = '{dst: 4'h5, payload: 28'hB00 + 28'(i)};
      pe_data = pk;
      pe_val  = 1'b1;
      if (i < 4) tx_exp.push_back(pk);
      @(negedge clk);
      check("bp_pe_rdy", pe_rdy, (i < 4));
      check("bp_data_val", r_data_val, 0);
      next_cycle();
    end
    pe_val = 1'b0;
    en_in  = 1'b1;
    @(negedge clk);
    check("bp_full_rdy", pe_rdy, 0);
    check("bp_drain_val", r_data_val, 1);
    next_cycle();
    @(negedge clk);
    check("bp_rdy_after_pop", pe_rdy, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    check("bp_drained_val", r_data_val, 0);
    check("bp_tx_count", tx_count, 7);
    check("bp_tx_queue_empty", tx_exp.size(), 0);

    // RX full, overflow, and o_en timing on drain
    next_cycle();
    pe_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pk = '{dst: 4'h9, payload: 28'hC00 + 28'(i)};
      d_in     = pk;
      d_in_val = 1'b1;
      rx_exp.push_back(pk);
      @(negedge clk);
      check("rxf_en_before", en_out, 1);
      next_cycle();
    end
    d_in     = '{dst: 4'hF, payload: 28'hDEAD};
    d_in_val = 1'b1;
    @(negedge clk);
    check("rxf_en_full", en_out, 0);
    check("rxf_rx_count", rx_count, 4);
    check("rxf_pe_val", pe_out_val, 1);
    check("rxf_ovf_before", overflow, 0);
    next_cycle();
    d_in_val   = 1'b0;
    pe_out_rdy = 1'b1;
    @(negedge clk);
    check("rxf_ovf_set", overflow, 1);
    check("rxf_rx_count_hold", rx_count, 4);
    check("rxf_en_not_early", en_out, 0);
    next_cycle();
    @(negedge clk);
    check("rxf_en_rise", en_out, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    check("rxf_drained", pe_out_val, 0);
    check("rxf_rx_queue_empty", rx_exp.size(), 0);

    // Concurrent random traffic on both paths
    tx_sent = 0;
    rx_sent = 0;
    for (int cyc = 0; cyc < 20000 && (tx_sent < 1000 || rx_sent < 1000); cyc++) begin
      next_cycle();
      pe_data = packet_t'($urandom);
      pe_val  = (tx_sent < 1000) && ($urandom_range(0, 3) != 0);
      if (pe_val && pe_rdy) begin
        tx_exp.push_back(pe_data);
        tx_sent++;
      end
      en_in    = 1'($urandom_range(0, 1));
      d_in     = packet_t'($urandom);
      d_in_val = (rx_sent < 1000) && en_out && ($urandom_range(0, 3) != 0);
      if (d_in_val) begin
        rx_exp.push_back(d_in);
        rx_sent++;
      end
      pe_out_rdy = 1'($urandom_range(0, 1));
    end
    next_cycle();
    pe_val     = 1'b0;
    d_in_val   = 1'b0;
    en_in      = 1'b1;
    pe_out_rdy = 1'b1;
    for (int cyc = 0; cyc < 100 && (tx_exp.size() != 0 || rx_exp.size() != 0); cyc++)
      next_cycle();
    @(negedge clk);
    check("rnd_tx_sent", tx_sent, 1000);
    check("rnd_rx_sent", rx_sent, 1000);
    check("rnd_tx_queue_empty", tx_exp.size(), 0);
    check("rnd_rx_queue_empty", rx_exp.size(), 0);
    check("rnd_tx_count", tx_count, 1007);
    check("rnd_rx_count", rx_count, 1004);
    check("rnd_ovf_sticky", overflow, 1);

    // Counter wrap (CNT_W=4): 17 TX pops -> count 1
    next_cycle();
    w_reset_n = 1'b1;
    w_en_in   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w_pe_data = '{dst: 4'h1, payload: 28'(i)};
      w_pe_val  = 1'b1;
      next_cycle();
    end
    w_pe_val = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("wrap_tx_count", w_tx_count, 1);

    // Fill both buffers, force overflow, then a one-cycle mid-run reset
    next_cycle();
    w_en_in      = 1'b0;
    w_pe_out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_pe_val   = (i < 2);
      w_pe_data  = '{dst: 4'h2, payload: 28'h100 + 28'(i)};
      w_d_in_val = 1'b1;
      w_d_in     = '{dst: 4'h3, payload: 28'h200 + 28'(i)};
      next_cycle();
    end
    w_pe_val   = 1'b0;
    w_d_in_val = 1'b0;
    @(negedge clk);
    check("mrst_pre_ovf", w_overflow, 1);
    check("mrst_pre_pe_val", w_pe_out_val, 1);
    check("mrst_pre_rx_count", w_rx_count, 4);
    next_cycle();
    w_reset_n = 1'b0;
    next_cycle();
    w_reset_n = 1'b1;
    w_en_in   = 1'b1;
    @(negedge clk);
    check("mrst_data_val", w_r_data_val, 0);
    check("mrst_pe_val", w_pe_out_val, 0);
    check("mrst_pe_rdy", w_pe_rdy, 1);
    check("mrst_en", w_en_out, 1);
    check("mrst_tx_count", w_tx_count, 0);
    check("mrst_rx_count", w_rx_count, 0);
    check("mrst_ovf", w_overflow, 0);
    next_cycle();
    @(negedge clk);
    check("mrst_tx_count_stays", w_tx_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
